uart_baud_gen: RTL

Parametrised UART baud-rate generator with a fractional-N accumulator, for the UART bus-driver path. It takes a runtime baud rate and produces single-cycle strobes: an oversampling tick, a mid-bit sample strobe and a bit tick, plus a legacy square-wave baud clock. The average tick rate is exact for any rate and needs no hardware divider. It feeds the UART TX and RX shifters and supports phase realignment on an RX start bit.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_frac_acc.sv | 49 ++++
 rtl/uart_baud_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART baud-rate generator.
package uart_pkg;

  localparam int UART_OVS_DEF     = 16;
  localparam int UART_DEFAULT_BPS = 115200;

  // Width of the per-cycle increment rate*OVS; OVS is a power of two.
  function automatic int uart_inc_width(input int ovs);
    return 32 + $clog2(ovs);
  endfunction

  // A rate is unusable if zero or if os ticks would come closer than 2 cycles.
  // Operands are zero-extended to 64 bits so the compare never truncates.
  function automatic logic uart_bps_err(input logic [63:0] inc,
                                        input logic [63:0] rate,
                                        input logic [63:0] half_clk);
    return (rate == 64'd0) || (inc > half_clk);
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional-N phase accumulator: adds inc every cycle and emits a raw
// (combinational) tick whenever the sum reaches CLK_HZ.
module uart_frac_acc #(
  parameter int CLK_HZ = 50_000_000,
  parameter int ACC_W  = $clog2(CLK_HZ) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  localparam logic [ACC_W:0] CLK_C = (ACC_W+1)'(CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum_s;

  // One extra bit keeps acc + inc from wrapping before the compare.
  assign sum_s = {1'b0, acc_q} + {1'b0, inc};

  // Next accumulator value and raw tick; clear beats hold beats step.
  always_comb begin
    acc_d = acc_q;
    tick  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (hold) begin
      acc_d = acc_q;
    end else if (sum_s >= CLK_C) begin
      acc_d = ACC_W'(sum_s - CLK_C);
      tick  = 1'b1;
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: rate latch, oversampling counter, mid/bit strobe
// decode and legacy square-wave baud clock around a fractional accumulator.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int OVS         = UART_OVS_DEF,
  parameter int DEFAULT_BPS = UART_DEFAULT_BPS,
  parameter int ACC_W       = $clog2(CLK_HZ) + 1
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        i_enable,
  input  logic [31:0] i_uart_bps,
  input  logic        i_bps_load,
  input  logic        i_sync,
  output logic        o_os_tick,
  output logic        o_mid_tick,
  output logic        o_bit_tick,
  output logic        o_uart_clk,
  output logic        o_bps_err
);

  localparam int               OVS_W       = $clog2(OVS);
  localparam int               INC_W       = uart_inc_width(OVS);
  localparam logic [63:0]      HALF_CLK    = 64'(CLK_HZ / 2);
  localparam logic [OVS_W-1:0] MID_CNT     = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] BIT_CNT     = OVS_W'(OVS - 1);
  localparam logic [31:0]      DEFAULT_R   = 32'(DEFAULT_BPS);
  localparam logic [INC_W-1:0] DEFAULT_INC = {DEFAULT_R, {OVS_W{1'b0}}};

  logic [31:0]      rate_q,     rate_d;
  logic [INC_W-1:0] inc_q,      inc_d;
  logic             err_q,      err_d;
  logic [OVS_W-1:0] os_cnt_q,   os_cnt_d;
  logic             os_tick_q,  os_tick_d;
  logic             mid_q,      mid_d;
  logic             bit_q,      bit_d;
  logic             uart_clk_q, uart_clk_d;

  logic [INC_W-1:0] inc_load_s;
  logic             err_s;
  logic             realign_s;
  logic             tick_s;

  // OVS is a power of two, so rate*OVS is a plain shift.
  assign inc_load_s = {i_uart_bps, {OVS_W{1'b0}}};
  assign err_s      = uart_bps_err(64'(inc_q), 64'(rate_q), HALF_CLK);
  assign realign_s  = i_sync | i_bps_load;

  // While the rate is invalid inc_q may exceed ACC_W bits, but clear is then
  // asserted so the truncated increment is never used.
  uart_frac_acc #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk   (sys_clk),
    .reset (sys_reset),
    .clear (realign_s | err_s),
    .hold  (~i_enable),
    .inc   (inc_q[ACC_W-1:0]),
    .tick  (tick_s)
  );

  // Rate latch, validity flag, os counter, strobes and baud clock next state.
  always_comb begin
    rate_d     = rate_q;
    inc_d      = inc_q;
    err_d      = err_s;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    mid_d      = 1'b0;
    bit_d      = 1'b0;
    uart_clk_d = uart_clk_q;

    if (i_bps_load) begin
      rate_d = i_uart_bps;
      inc_d  = inc_load_s;
      err_d  = uart_bps_err(64'(inc_load_s), 64'(i_uart_bps), HALF_CLK);
    end else begin
      rate_d = rate_q;
    end

    if (realign_s || err_s) begin
      os_cnt_d   = '0;
      uart_clk_d = 1'b0;
    end else if (!i_enable) begin
      os_cnt_d   = os_cnt_q;
      uart_clk_d = uart_clk_q;
    end else if (tick_s) begin
      os_tick_d = 1'b1;
      mid_d     = (os_cnt_q == MID_CNT);
      bit_d     = (os_cnt_q == BIT_CNT);
      os_cnt_d  = os_cnt_q + OVS_W'(1);
      if (mid_d || bit_d) begin
        uart_clk_d = ~uart_clk_q;
      end else begin
        uart_clk_d = uart_clk_q;
      end
    end else begin
      os_cnt_d   = os_cnt_q;
      uart_clk_d = uart_clk_q;
    end
  end

  // State and output registers; reset reverts to the default rate.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      rate_q     <= DEFAULT_R;
      inc_q      <= DEFAULT_INC;
      err_q      <= 1'b0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
      uart_clk_q <= 1'b0;
    end else begin
      rate_q     <= rate_d;
      inc_q      <= inc_d;
      err_q      <= err_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
      uart_clk_q <= uart_clk_d;
    end
  end

  assign o_os_tick  = os_tick_q;
  assign o_mid_tick = mid_q;
  assign o_bit_tick = bit_q;
  assign o_uart_clk = uart_clk_q;
  assign o_bps_err  = err_q;

endmodule
